pipe_spawn_scheduler: RTL and testbench

- Sequences the three pipe slots of the pipe animation datapath.
- Owns the game-run FSM (IDLE/RUN/OVER) and a score-dependent spawn interval timer.
- Picks a free slot and issues a one-cycle spawn pulse carrying a pseudo-random gap Y and the score to latch.
- Tracks slot occupancy from the per-slot end-of-map pulses returned by the datapath.

---
 rtl/pipe_spawn_scheduler.sv | 125 ++++++++++++
 tb/tb_pipe_spawn_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_spawn_scheduler.sv
// Game-run FSM, score-paced spawn timer and lowest-free slot allocator for
// the three-slot pipe animation datapath.
module pipe_spawn_scheduler #(
   parameter int         BASE_INTERVAL = 120,
   parameter int         MIN_INTERVAL  = 60,
   parameter int         INTERVAL_STEP = 2,
   parameter int         Y_MIN         = 100,
   parameter int         Y_MAX         = 380,
   parameter logic [9:0] LFSR_SEED     = 10'h2A5
) (
   input  logic       animationCLOCK,
   input  logic       resetN,
   input  logic       start,
   input  logic       crash,
   input  logic [9:0] score,
   input  logic [2:0] slotDone,
   output logic [2:0] spawnEn,
   output logic [9:0] spawnY,
   output logic [9:0] spawnScore,
   output logic [2:0] slotBusy,
   output logic [1:0] gameState,
   output logic       pending
);
   localparam int          RANGE  = Y_MAX - Y_MIN;
   localparam logic [15:0] BASE16 = 16'(BASE_INTERVAL);
   localparam logic [15:0] MIN16  = 16'(MIN_INTERVAL);
   localparam logic [15:0] STEP16 = 16'(INTERVAL_STEP);
   localparam logic [15:0] SPAN16 = 16'(BASE_INTERVAL - MIN_INTERVAL);
   localparam logic [8:0]  RANGE9 = 9'(RANGE);
   localparam logic [9:0]  YMIN10 = 10'(Y_MIN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t      state_reg;
   logic [15:0] timer_reg;
   logic [9:0]  lfsr_reg;

   logic [15:0] red;
   logic [15:0] interval;
   logic        expired;
   logic        spawn_ok;
   logic [2:0]  free_slots;
   logic [2:0]  pick;
   logic [8:0]  r;
   logic [9:0]  y_next;

   always_comb begin
      red      = 16'(score) * STEP16;
      interval = (red >= SPAN16) ? MIN16 : BASE16 - red;
   end

   // >= rather than == so a score jump mid-count still triggers at once
   assign expired = (timer_reg >= interval - 16'd1);

   assign free_slots = ~slotBusy;
   assign pick[0]    = free_slots[0];
   generate
      for (genvar gi = 1; gi < 3; gi++) begin : g_pick
         assign pick[gi] = free_slots[gi] & ~(|free_slots[gi-1:0]);
      end
   endgenerate

   // Out-of-range draws fold back to the bottom of the window
   assign r      = lfsr_reg[8:0];
   assign y_next = (r <= RANGE9) ? YMIN10 + {1'b0, r}
                                 : YMIN10 + {1'b0, r - RANGE9 - 9'd1};

   assign spawn_ok = (state_reg == RUN) && !crash && (expired || pending)
                     && (|free_slots);

   always_ff @(posedge animationCLOCK) begin
      if (!resetN) begin
         state_reg  <= IDLE;
         timer_reg  <= 16'd0;
         lfsr_reg   <= LFSR_SEED;
         spawnEn    <= 3'b000;
         spawnY     <= 10'd0;
         spawnScore <= 10'd0;
         slotBusy   <= 3'b000;
         pending    <= 1'b0;
      end else begin
         spawnEn <= 3'b000;
         case (state_reg)
            IDLE: begin
               timer_reg <= 16'd0;
               pending   <= 1'b0;
               slotBusy  <= 3'b000;
               if (start) state_reg <= RUN;
            end
            RUN: begin
               lfsr_reg <= {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
               if (crash) begin
                  state_reg <= OVER;
                  pending   <= 1'b0;
                  slotBusy  <= slotBusy & ~slotDone;
               end else if (spawn_ok) begin
                  spawnEn    <= pick;
                  spawnY     <= y_next;
                  spawnScore <= score;
                  slotBusy   <= (slotBusy & ~slotDone) | pick;
                  timer_reg  <= 16'd0;
                  pending    <= 1'b0;
               end else begin
                  slotBusy <= slotBusy & ~slotDone;
                  if (expired || pending) pending <= 1'b1;
                  else                    timer_reg <= timer_reg + 16'd1;
               end
            end
            OVER: begin
               pending  <= 1'b0;
               slotBusy <= slotBusy & ~slotDone;
               if (start) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign gameState = state_reg;

endmodule

// File: tb/tb_pipe_spawn_scheduler.sv
// Bench for pipe_spawn_scheduler: behavioural model feeding a spawn scoreboard,
// per-cycle state comparison and directed timing scenarios.
`timescale 1ns/1ps
module tb_pipe_spawn_scheduler;
   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       start = 1'b0;
   logic       crash = 1'b0;
   logic [9:0] score = 10'd0;
   logic [2:0] slotDone = 3'b000;
   logic [2:0] spawnEn;
   logic [9:0] spawnY;
   logic [9:0] spawnScore;
   logic [2:0] slotBusy;
   logic [1:0] gameState;
   logic       pending;

   always #5 clk = ~clk;

   pipe_spawn_scheduler dut (
      .animationCLOCK(clk),
      .resetN(resetN),
      .start(start),
      .crash(crash),
      .score(score),
      .slotDone(slotDone),
      .spawnEn(spawnEn),
      .spawnY(spawnY),
      .spawnScore(spawnScore),
      .slotBusy(slotBusy),
      .gameState(gameState),
      .pending(pending)
   );

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [2:0] en;
      int         y;
      int         sc;
   } spawn_t;

   spawn_t exp_q[$];

   int         m_state = 0;
   logic [2:0] m_busy = 3'b000;
   logic [2:0] m_en = 3'b000;
   bit         m_pend = 1'b0;
   int         m_timer = 0;
   int         m_y = 0;
   int         m_sc = 0;
   logic [9:0] m_lfsr = 10'h2A5;

   // Reference model, driven only by the bench's own inputs
   always @(posedge clk) begin : model_b
      int         iv;
      int         red;
      int         rr;
      bit         due;
      logic [2:0] nb;
      logic [2:0] pk;
      spawn_t     s;
      m_en = 3'b000;
      if (!resetN) begin
         m_state = 0; m_busy = 3'b000; m_pend = 1'b0; m_timer = 0;
         m_lfsr = 10'h2A5; m_y = 0; m_sc = 0;
      end else if (m_state == 0) begin
         m_busy = 3'b000; m_pend = 1'b0; m_timer = 0;
         if (start) m_state = 1;
      end else if (m_state == 1) begin
         red = int'(score) * 2;
         iv  = (red >= 60) ? 60 : 120 - red;
         nb  = m_busy & ~slotDone;
         due = (m_timer >= iv - 1) || m_pend;
         pk  = !m_busy[0] ? 3'b001 : !m_busy[1] ? 3'b010 : !m_busy[2] ? 3'b100 : 3'b000;
         if (crash) begin
            m_state = 2;
            m_pend  = 1'b0;
         end else if (due && pk != 3'b000) begin
            rr   = int'(m_lfsr[8:0]);
            s.en = pk;
            s.y  = (rr <= 280) ? 100 + rr : 100 + rr - 281;
            s.sc = int'(score);
            exp_q.push_back(s);
            m_en = pk; m_y = s.y; m_sc = s.sc;
            nb = nb | pk;
            m_timer = 0;
            m_pend  = 1'b0;
         end else if (due) begin
            m_pend = 1'b1;
         end else begin
            m_timer++;
         end
         m_busy = nb;
         m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      end else begin
         m_pend = 1'b0;
         m_busy = m_busy & ~slotDone;
         if (start) m_state = 0;
      end
   end

   int n_spawn = 0;
   bit seen_y [1024];

   always @(negedge clk) begin : mon_b
      spawn_t s;
      check("state", int'(gameState), m_state);
      check("busy", int'(slotBusy), int'(m_busy));
      check("pend", int'(pending), int'(m_pend));
      check("en", int'(spawnEn), int'(m_en));
      check("y_hold", int'(spawnY), m_y);
      check("sc_hold", int'(spawnScore), m_sc);
      if (spawnEn != 3'b000) begin
         n_spawn++;
         if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
         end else begin
            s = exp_q.pop_front();
            check("sb_en", int'(spawnEn), int'(s.en));
            check("sb_y", int'(spawnY), s.y);
            check("sb_score", int'(spawnScore), s.sc);
         end
         check("y_lo", int'(spawnY >= 10'd100), 1);
         check("y_hi", int'(spawnY <= 10'd380), 1);
         seen_y[spawnY] = 1'b1;
         $display("spawn #%0d slot=%b y=%0d score=%0d", n_spawn, spawnEn, spawnY, spawnScore);
      end
   end

   task automatic wait_spawn(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (spawnEn == 3'b000 && n < limit);
      if (spawnEn == 3'b000) check("spawn_timeout", 0, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_state"}, int'(gameState), 0);
      check({tag, "_en"}, int'(spawnEn), 0);
      check({tag, "_y"}, int'(spawnY), 0);
      check({tag, "_sc"}, int'(spawnScore), 0);
      check({tag, "_busy"}, int'(slotBusy), 0);
      check({tag, "_pend"}, int'(pending), 0);
   endtask

   initial begin
      int n;
      int first_y;
      int base;
      int cnt;
      int cyc;

      repeat (3) @(negedge clk);
      check_zero("rst");
      resetN = 1'b1;
      @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      check("run", int'(gameState), 1);

      wait_spawn(200, n); check("t1", n, 120); check("en1", int'(spawnEn), 1);
      check("sc1", int'(spawnScore), 0);
      first_y = int'(spawnY);
      wait_spawn(200, n); check("t2", n, 120); check("en2", int'(spawnEn), 2);
      wait_spawn(200, n); check("t3", n, 120); check("en3", int'(spawnEn), 4);

      score = 10'd40;
      repeat (60) @(negedge clk);
      check("pend_set", int'(pending), 1);
      check("pend_busy", int'(slotBusy), 7);
      slotDone = 3'b010; @(negedge clk); slotDone = 3'b000;
      check("pd_wait_en", int'(spawnEn), 0);
      check("pd_wait_pend", int'(pending), 1);
      @(negedge clk);
      check("pd_en", int'(spawnEn), 2);
      check("pd_clear", int'(pending), 0);

      slotDone = 3'b101; @(negedge clk); slotDone = 3'b000;
      wait_spawn(200, n); check("t_score40", n + 1, 60); check("en_s40", int'(spawnEn), 1);
      score = 10'd10;
      wait_spawn(200, n); check("t_score10", n, 100); check("en_s10", int'(spawnEn), 4);

      slotDone = 3'b010; @(negedge clk); slotDone = 3'b000;
      repeat (98) @(negedge clk);
      crash = 1'b1; @(negedge clk); crash = 1'b0;
      check("crash_state", int'(gameState), 2);
      check("crash_en", int'(spawnEn), 0);
      check("over_busy", int'(slotBusy), 5);
      slotDone = 3'b111; @(negedge clk); slotDone = 3'b000;
      check("over_clear", int'(slotBusy), 0);
      start = 1'b1; @(negedge clk); start = 1'b0;
      check("idle", int'(gameState), 0);
      start = 1'b1; @(negedge clk); start = 1'b0;
      check("rerun", int'(gameState), 1);
      slotDone = 3'b001; @(negedge clk); slotDone = 3'b000;
      check("stray_busy", int'(slotBusy), 0);
      check("stray_pend", int'(pending), 0);
      wait_spawn(200, n); check("t_restart", n + 1, 100); check("en_restart", int'(spawnEn), 1);

      base = n_spawn;
      cyc = 0;
      while (n_spawn - base < 1000 && cyc < 80000) begin
         score = 10'($urandom_range(25, 40));
         slotDone = ($urandom_range(0, 63) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         @(negedge clk);
         cyc++;
      end
      slotDone = 3'b000;
      check("rand_count", int'(n_spawn - base >= 1000), 1);
      cnt = 0;
      for (int i = 0; i < 1024; i++) if (seen_y[i]) cnt++;
      check("distinct", int'(cnt >= 200), 1);

      score = 10'd40;
      n = 0;
      while (!(pending && slotBusy == 3'b111) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("pre_rst_pend", int'(pending), 1);
      check("pre_rst_busy", int'(slotBusy), 7);
      resetN = 1'b0; @(negedge clk); resetN = 1'b1;
      check_zero("mid_rst");
      score = 10'd0;
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_spawn(200, n); check("t_after_rst", n, 120);
      check("en_after_rst", int'(spawnEn), 1);
      check("y_repeat", int'(spawnY), first_y);
      @(negedge clk);
      check("sb_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
